// File: rtl/mdu_sched_if.sv
// Core-side request/response bundle for the M-extension sequencer.
// Latency: none (wires only).
// Backpressure: req_ready/stall driven by the slave; master holds req_valid until accepted.
//   master: EX stage (drives req_valid, funct3, rs1, rs2, flush)
//   slave : mdu_sched (drives req_ready, stall, resp_valid, resp_data)
interface mdu_sched_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            stall;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;

    modport master (
        output req_valid, funct3, rs1, rs2, flush,
        input  req_ready, stall, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, funct3, rs1, rs2, flush,
        output req_ready, stall, resp_valid, resp_data
    );
endinterface

// File: rtl/mdu_sched.sv
// Sequencer for RV32M ops: drives a shared pipelined multiplier and an iterative divider.
// Latency: MUL MUL_LAT+1 cycles, div-by-zero/overflow 1 cycle, divide 1 cycle after div_done.
// Backpressure: one op at a time; req_ready only in IDLE, stall holds the core until done.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   core (slave)         req_valid/req_ready/funct3/rs1/rs2/flush in, stall/resp_valid/resp_data out
//   mul_a_o/mul_b_o      registered multiplier operands + signedness flags, mul_p_i product
//   div_start_o/abort_o  divider control pulses; div_sgn_o, div_n_o, div_d_o operands
//   div_done_i/q_i/r_i   divider completion pulse and results
module mdu_sched #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mdu_sched_if.slave        core,
    output logic [XLEN-1:0]   mul_a_o,
    output logic [XLEN-1:0]   mul_b_o,
    output logic              mul_a_sgn_o,
    output logic              mul_b_sgn_o,
    input  logic [2*XLEN-1:0] mul_p_i,
    output logic              div_start_o,
    output logic              div_abort_o,
    output logic              div_sgn_o,
    output logic [XLEN-1:0]   div_n_o,
    output logic [XLEN-1:0]   div_d_o,
    input  logic              div_done_i,
    input  logic [XLEN-1:0]   div_q_i,
    input  logic [XLEN-1:0]   div_r_i
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL_WAIT = 2'd1;
    localparam logic [1:0] S_DIV_RUN  = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic            mul_a_sgn_q, mul_a_sgn_d, mul_b_sgn_q, mul_b_sgn_d;
    logic            div_sgn_q, div_sgn_d;
    logic [XLEN-1:0] div_n_q, div_n_d, div_d_q, div_d_d;
    logic            div_start_q, div_start_d;
    logic            div_abort_q, div_abort_d;

    logic            div_by_zero;
    logic            div_ovf;

    // Cases the divider never sees: x/0 and signed INT_MIN / -1.
    assign div_by_zero = (core.rs2 == '0);
    assign div_ovf     = !core.funct3[0] && (core.rs1 == INT_MIN) && (core.rs2 == '1);

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_a_sgn_d = mul_a_sgn_q;
        mul_b_sgn_d = mul_b_sgn_q;
        div_sgn_d   = div_sgn_q;
        div_n_d     = div_n_q;
        div_d_d     = div_d_q;
        div_start_d = 1'b0;
        div_abort_d = 1'b0;

        if (core.flush) begin
            // Flush wins over everything; only a running divide needs cancelling.
            state_d     = S_IDLE;
            div_abort_d = (state_q == S_DIV_RUN);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (core.req_valid) begin
                        funct3_d    = core.funct3;
                        mul_a_d     = core.rs1;
                        mul_b_d     = core.rs2;
                        mul_a_sgn_d = (core.funct3 != 3'b011);
                        mul_b_sgn_d = (core.funct3[2:1] == 2'b00);
                        div_sgn_d   = !core.funct3[0];
                        div_n_d     = core.rs1;
                        div_d_d     = core.rs2;
                        if (!core.funct3[2]) begin
                            state_d = S_MUL_WAIT;
                            cnt_d   = CW'(MUL_LAT - 1);
                        end else if (div_by_zero) begin
                            state_d     = S_DONE;
                            resp_data_d = core.funct3[1] ? core.rs1 : '1;
                        end else if (div_ovf) begin
                            state_d     = S_DONE;
                            resp_data_d = core.funct3[1] ? '0 : INT_MIN;
                        end else begin
                            state_d     = S_DIV_RUN;
                            div_start_d = 1'b1;
                        end
                    end
                end
                S_MUL_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d     = S_DONE;
                        resp_data_d = (funct3_q == 3'b000) ? mul_p_i[XLEN-1:0]
                                                           : mul_p_i[2*XLEN-1:XLEN];
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DIV_RUN: begin
                    if (div_done_i) begin
                        state_d     = S_DONE;
                        resp_data_d = funct3_q[1] ? div_r_i : div_q_i;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            funct3_q    <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_a_sgn_q <= 1'b0;
            mul_b_sgn_q <= 1'b0;
            div_sgn_q   <= 1'b0;
            div_n_q     <= '0;
            div_d_q     <= '0;
            div_start_q <= 1'b0;
            div_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_a_sgn_q <= mul_a_sgn_d;
            mul_b_sgn_q <= mul_b_sgn_d;
            div_sgn_q   <= div_sgn_d;
            div_n_q     <= div_n_d;
            div_d_q     <= div_d_d;
            div_start_q <= div_start_d;
            div_abort_q <= div_abort_d;
        end
    end

    // The IDLE-decoded outputs are gated by rst_n so every output reads 0 while in reset.
    assign core.req_ready  = rst_n && (state_q == S_IDLE);
    assign core.stall      = rst_n && (((state_q == S_IDLE) && core.req_valid) ||
                                       (state_q == S_MUL_WAIT) || (state_q == S_DIV_RUN));
    assign core.resp_valid = (state_q == S_DONE) && !core.flush;
    assign core.resp_data  = resp_data_q;

    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign mul_a_sgn_o = mul_a_sgn_q;
    assign mul_b_sgn_o = mul_b_sgn_q;
    assign div_start_o = div_start_q;
    assign div_abort_o = div_abort_q;
    assign div_sgn_o   = div_sgn_q;
    assign div_n_o     = div_n_q;
    assign div_d_o     = div_d_q;
endmodule
